nibble_serial_adder_ctrl: RTL and testbench
===========================================

Name: nibble_serial_adder_ctrl

Overview:
- Sequencer that performs a W-bit add or subtract, W = 4*NIBBLES, by driving one external 4-bit ripple-adder slice once per clock.
- Each cycle it presents one operand nibble, LSB nibble first, and holds the carry between nibbles in a flop.
- It collects the sum nibbles into a result register.
- Sits between the lab top level (switch/button inputs) and a single shared 4-bit adder instance.

Parameters:
- NIBBLES, 4, number of 4-bit slices per operation; W = 4*NIBBLES (default 16). Legal range 2..16.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high; clears all state.
- Run  input  1  level start request, sampled in IDLE.
- Sub  input  1  0 = A+B, 1 = A-B; captured at start.
- A_in  input  W  operand A; captured at start.
- B_in  input  W  operand B; captured at start.
- adder_A  output  4  nibble of A presented to the slice.
- adder_B  output  4  nibble of effective B (inverted when Sub) presented to the slice.
- adder_cin  output  1  carry into the slice.
- adder_S  input  4  slice sum, combinational from adder_A/adder_B/adder_cin.
- adder_cout  input  1  slice carry out.
- Sum  output  W  result of last completed operation.
- Cout  output  1  final carry out; for subtract, 1 = no borrow.
- Overflow  output  1  two's-complement signed overflow of last operation.
- Busy  output  1  high in CALC.
- Done  output  1  high in HOLD.

Behaviour:
- Reset (async, any state): state = IDLE, count = 0, carry = 0, operand and staging registers = 0, Sum = 0, Cout = 0, Overflow = 0, Busy = 0, Done = 0, adder_A/adder_B/adder_cin = 0.
- States: IDLE, CALC, HOLD.
- IDLE: Busy = 0, Done = 0, slice outputs = 0.
  - If Run = 1 at an edge: A_reg <= A_in; B_reg <= Sub ? ~B_in : B_in; carry <= Sub; count <= 0; go to CALC.
- CALC, one cycle per nibble:
  - Drive adder_A = A_reg[3:0], adder_B = B_reg[3:0], adder_cin = carry.
  - At each edge: A_reg and B_reg shift right by 4; staging register shifts right by 4 with adder_S entering bits [W-1:W-4]; carry <= adder_cout; count <= count+1.
  - Busy = 1.
- Last nibble (count == NIBBLES-1), at that edge:
  - Sum <= {adder_S, staging[W-1:4]}; Cout <= adder_cout.
  - Overflow <= (adder_A[3] == adder_B[3]) && (adder_S[3] != adder_A[3]).
  - Go to HOLD.
- Sum, Cout and Overflow change only on that completion edge. They hold the previous result throughout CALC.
- HOLD: Done = 1, slice outputs = 0. Stays in HOLD while Run = 1; goes to IDLE at the first edge with Run = 0. A held Run therefore yields exactly one operation.
- Latency: Run sampled at edge E0; CALC spans NIBBLES cycles; Sum valid and Done = 1 after edge E0+NIBBLES; next start accepted no earlier than edge E0+NIBBLES+2.
- Operands and Sub changing after E0 are ignored until the next start.
- Reset asserted mid-CALC aborts immediately. The partial result is discarded and Sum reads 0.
- The slice outputs are combinational from registers only; there is no path from adder_S/adder_cout back to any output.
- Width: carry is 1 bit; count is ceil(log2(NIBBLES)) bits; no wrap is reachable in CALC.

Test Plan (NIBBLES=4):
- A=0x1234, B=0x4321, Sub=0, Run pulse -> Busy for 4 cycles; then Sum=0x5555, Cout=0, Overflow=0, Done=1 exactly 4 edges after the start edge.
- A=0xFFFF, B=0x0001, Sub=0 -> carry propagates through all 4 nibbles; Sum=0x0000, Cout=1, Overflow=0; adder_cin sequence observed 0,1,1,1.
- A=0x7FFF, B=0x0001, Sub=0 -> Sum=0x8000, Cout=0, Overflow=1.
- Sub=1 cases:
  - A=0x0005, B=0x0007 -> Sum=0xFFFE, Cout=0, Overflow=0.
  - A=0x8000, B=0x0001 -> Sum=0x7FFF, Cout=1, Overflow=1.
- Run held high through and after Done, with A_in/B_in changed during CALC -> result uses the captured operands; Sum stays stable in HOLD; no second operation; Run low returns to IDLE on the next edge.
- Reset asserted asynchronously during the 2nd CALC cycle -> Busy=0, Sum=0, adder_* = 0 before the next clock edge; a fresh Run then completes a correct operation.

Source files
------------

// File: rtl/nibble_serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder_ctrl
//
// Purpose:
//   Performs a W-bit add or subtract (W = 4*NIBBLES) by driving one external
//   4-bit ripple-adder slice once per clock. The LSB nibble goes first. The
//   carry between nibbles is held in a flop, and the sum nibbles are collected
//   into a result register.
//
// Ports:
//   Clk         in   system clock, rising edge
//   Reset       in   asynchronous, active-high; clears all state
//   Run         in   level start request, sampled in IDLE
//   Sub         in   0 = A+B, 1 = A-B (captured at start)
//   A_in, B_in  in   W-bit operands (captured at start)
//   adder_A     out  nibble of A presented to the slice
//   adder_B     out  nibble of effective B (inverted when subtracting)
//   adder_cin   out  carry into the slice
//   adder_S     in   slice sum (combinational from adder_A/B/cin)
//   adder_cout  in   slice carry out
//   Sum         out  result of last completed operation
//   Cout        out  final carry out (subtract: 1 = no borrow)
//   Overflow    out  two's-complement signed overflow of last operation
//   Busy        out  high in CALC
//   Done        out  high in HOLD
//   dbg_state   out  current FSM state (0 IDLE, 1 CALC, 2 HOLD)
//
// Handshake:
//   Run is a level request. It is accepted only in IDLE; the accepting edge
//   captures the operands and Sub. Busy is high while the operation runs. Done
//   is high once Sum/Cout/Overflow are valid, and it stays high until Run is
//   seen low. Holding Run high therefore starts exactly one operation.
// -----------------------------------------------------------------------------
module nibble_serial_adder_ctrl #(
   parameter int NIBBLES = 4
) (
   input  logic                   Clk,
   input  logic                   Reset,
   input  logic                   Run,
   input  logic                   Sub,
   input  logic [4*NIBBLES-1:0]   A_in,
   input  logic [4*NIBBLES-1:0]   B_in,
   output logic [3:0]             adder_A,
   output logic [3:0]             adder_B,
   output logic                   adder_cin,
   input  logic [3:0]             adder_S,
   input  logic                   adder_cout,
   output logic [4*NIBBLES-1:0]   Sum,
   output logic                   Cout,
   output logic                   Overflow,
   output logic                   Busy,
   output logic                   Done,
   output logic [1:0]             dbg_state
);

   localparam int W  = 4 * NIBBLES;
   localparam int CW = $clog2(NIBBLES);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t         state, state_nxt;
   logic [W-1:0]   a_reg, b_reg;
   logic [W-1:0]   staging;
   logic [W-1:0]   staging_nxt;
   logic           carry;
   logic [CW-1:0]  count;
   logic           last;

   assign last = (count == CW'(NIBBLES - 1));

   // The new slice sum enters at the top and everything else moves down one
   // nibble. After NIBBLES shifts, the first nibble sits at the bottom.
   assign staging_nxt = {adder_S, (W-4)'(staging >> 4)};

   // ---------------- state register ----------------
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (Run)  state_nxt = CALC;
         CALC:    if (last) state_nxt = HOLD;
         HOLD:    if (!Run) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------- output logic ----------------
   // The slice is driven only from registers. adder_S/adder_cout never feed
   // back combinationally to an output.
   always_comb begin
      adder_A   = 4'd0;
      adder_B   = 4'd0;
      adder_cin = 1'b0;
      Busy      = 1'b0;
      Done      = 1'b0;
      case (state)
         CALC: begin
            adder_A   = a_reg[3:0];
            adder_B   = b_reg[3:0];
            adder_cin = carry;
            Busy      = 1'b1;
         end
         HOLD:    Done = 1'b1;
         default: ;
      endcase
   end

   assign dbg_state = state;

   // ---------------- datapath ----------------
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         a_reg    <= '0;
         b_reg    <= '0;
         staging  <= '0;
         carry    <= 1'b0;
         count    <= '0;
         Sum      <= '0;
         Cout     <= 1'b0;
         Overflow <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (Run) begin
                  a_reg <= A_in;
                  // Subtract is A + ~B + 1. The +1 is the initial carry.
                  b_reg <= Sub ? ~B_in : B_in;
                  carry <= Sub;
                  count <= '0;
               end
            end
            CALC: begin
               a_reg   <= a_reg >> 4;
               b_reg   <= b_reg >> 4;
               staging <= staging_nxt;
               carry   <= adder_cout;
               count   <= count + CW'(1);
               if (last) begin
                  Sum      <= staging_nxt;
                  Cout     <= adder_cout;
                  // On the last nibble, a_reg/b_reg bit 3 hold the operand
                  // sign bits, which are the bits presented to the slice.
                  Overflow <= (a_reg[3] == b_reg[3]) && (adder_S[3] != a_reg[3]);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
module tb_nibble_serial_adder_ctrl;

   localparam int NIBBLES = 4;
   localparam int W       = 4 * NIBBLES;

   // ---------------- clock / reset ----------------
   logic Clk = 1'b0;
   logic Reset;
   always #5 Clk = ~Clk;

   logic          Run, Sub;
   logic [W-1:0]  A_in, B_in;
   logic [3:0]    adder_A, adder_B, adder_S;
   logic          adder_cin, adder_cout;
   logic [W-1:0]  Sum;
   logic          Cout, Overflow, Busy, Done;
   logic [1:0]    dbg_state;

   // Behavioural model of the external 4-bit ripple slice.
   assign {adder_cout, adder_S} = {1'b0, adder_A} + {1'b0, adder_B} + {4'd0, adder_cin};

   nibble_serial_adder_ctrl #(.NIBBLES(NIBBLES)) dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .Run        (Run),
      .Sub        (Sub),
      .A_in       (A_in),
      .B_in       (B_in),
      .adder_A    (adder_A),
      .adder_B    (adder_B),
      .adder_cin  (adder_cin),
      .adder_S    (adder_S),
      .adder_cout (adder_cout),
      .Sum        (Sum),
      .Cout       (Cout),
      .Overflow   (Overflow),
      .Busy       (Busy),
      .Done       (Done),
      .dbg_state  (dbg_state)
   );

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_fail   = 0;
   logic [W-1:0] exp_sum_q[$];   // expected result of each completed operation
   logic [W-1:0] held_sum;       // Sum expected to be held between operations

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         sub;
      logic [W-1:0] e_sum;
      logic         e_cout;
      logic         e_ovf;
   } vec_t;

   vec_t vecs[7];

   // ---------------- driver ----------------
   // Run is pulsed for one edge. During CALC the operands are scrambled to
   // show that only the values captured at the start edge are used.
   task automatic run_op(input vec_t v);
      logic [W-1:0] beff;
      logic         c;
      logic [4:0]   t;
      @(negedge Clk);
      A_in = v.a; B_in = v.b; Sub = v.sub; Run = 1'b1;
      @(negedge Clk);                   // start edge E0 has passed
      Run  = 1'b0;
      beff = v.sub ? ~v.b : v.b;
      c    = v.sub;
      for (int k = 0; k < NIBBLES; k++) begin
         if (k > 0) @(negedge Clk);
         chk("busy_calc", {31'd0, Busy}, 32'd1);
         chk("done_calc", {31'd0, Done}, 32'd0);
         chk("sum_held_calc", {16'd0, Sum}, {16'd0, held_sum});
         chk("adder_A", {28'd0, adder_A}, {28'd0, v.a[4*k +: 4]});
         chk("adder_B", {28'd0, adder_B}, {28'd0, beff[4*k +: 4]});
         chk("adder_cin", {31'd0, adder_cin}, {31'd0, c});
         t = {1'b0, v.a[4*k +: 4]} + {1'b0, beff[4*k +: 4]} + {4'd0, c};
         c = t[4];
         A_in = W'($urandom); B_in = W'($urandom); Sub = 1'($urandom);
      end
      @(negedge Clk);                   // after E0+NIBBLES
      exp_sum_q.push_back(v.e_sum);
      chk("done_hold", {31'd0, Done}, 32'd1);
      chk("busy_hold", {31'd0, Busy}, 32'd0);
      chk("sum", {16'd0, Sum}, {16'd0, exp_sum_q.pop_front()});
      chk("cout", {31'd0, Cout}, {31'd0, v.e_cout});
      chk("overflow", {31'd0, Overflow}, {31'd0, v.e_ovf});
      chk("adder_A_hold", {28'd0, adder_A}, 32'd0);
      held_sum = v.e_sum;
      @(negedge Clk);                   // Run low -> IDLE
      chk("done_idle", {31'd0, Done}, 32'd0);
      chk("state_idle", {30'd0, dbg_state}, 32'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
      vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
      vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
      vecs[3] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
      vecs[4] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
      vecs[5] = '{16'h0003, 16'h0003, 1'b1, 16'h0000, 1'b1, 1'b0};
      vecs[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};

      Reset = 1'b1; Run = 1'b0; Sub = 1'b0; A_in = '0; B_in = '0;
      held_sum = '0;
      repeat (2) @(negedge Clk);
      chk("rst_sum", {16'd0, Sum}, 32'd0);
      chk("rst_busy", {31'd0, Busy}, 32'd0);
      chk("rst_done", {31'd0, Done}, 32'd0);
      chk("rst_cout_ovf", {30'd0, Cout, Overflow}, 32'd0);
      chk("rst_adder", {23'd0, adder_A, adder_B, adder_cin}, 32'd0);
      Reset = 1'b0;

      for (int i = 0; i < 7; i++) run_op(vecs[i]);

      // Run held high through and after Done: exactly one operation.
      @(negedge Clk);
      A_in = 16'h00FF; B_in = 16'h0F0F; Sub = 1'b0; Run = 1'b1;
      for (int k = 0; k < NIBBLES; k++) begin
         @(negedge Clk);
         A_in = 16'hAAAA; B_in = 16'h5555;
         chk("held_busy", {31'd0, Busy}, 32'd1);
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge Clk);
         chk("held_done", {31'd0, Done}, 32'd1);
         chk("held_busy_hold", {31'd0, Busy}, 32'd0);
         chk("held_sum", {16'd0, Sum}, 32'h0000_100E);
      end
      Run = 1'b0;
      @(negedge Clk);
      chk("held_release_done", {31'd0, Done}, 32'd0);
      chk("held_release_state", {30'd0, dbg_state}, 32'd0);
      held_sum = 16'h100E;

      // Asynchronous reset during the second CALC cycle.
      @(negedge Clk);
      A_in = 16'h1111; B_in = 16'h2222; Sub = 1'b0; Run = 1'b1;
      @(negedge Clk);
      Run = 1'b0;
      @(negedge Clk);                   // second CALC cycle
      #1 Reset = 1'b1;
      #1;
      chk("arst_busy", {31'd0, Busy}, 32'd0);
      chk("arst_sum", {16'd0, Sum}, 32'd0);
      chk("arst_adder", {23'd0, adder_A, adder_B, adder_cin}, 32'd0);
      chk("arst_state", {30'd0, dbg_state}, 32'd0);
      #1 Reset = 1'b0;
      held_sum = '0;
      run_op('{16'h0F0F, 16'h0101, 1'b0, 16'h1010, 1'b0, 1'b0});

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
